// File: rtl/axis_frame_arbiter.sv
// Round-robin frame arbiter: grants whole AXI4-Stream video frames from
// NUM_INPUTS sources to one shared engine, draining out-of-frame beats.
module axis_frame_arbiter #(
    parameter int C_AXIS_TDATA_WIDTH = 24,
    parameter int NUM_INPUTS         = 4,
    parameter int IMG_HEIGHT         = 10
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic                                     enable,
    input  logic [NUM_INPUTS-1:0]                    s_axis_tvalid,
    output logic [NUM_INPUTS-1:0]                    s_axis_tready,
    input  logic [NUM_INPUTS*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS-1:0]                    s_axis_tlast,
    input  logic [NUM_INPUTS-1:0]                    s_axis_tuser,
    output logic                                     m00_axis_tvalid,
    input  logic                                     m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]            m00_axis_tdata,
    output logic                                     m00_axis_tlast,
    output logic                                     m00_axis_tuser,
    output logic [$clog2(NUM_INPUTS)-1:0]            grant_id,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic                                     sync_error
);

    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int GW = $clog2(NUM_INPUTS);
    localparam int LW = $clog2(IMG_HEIGHT) + 1;
    localparam logic [LW-1:0] LAST_LINE = LW'(IMG_HEIGHT - 1);
    localparam logic [GW-1:0] LAST_IN   = GW'(NUM_INPUTS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   rr_ptr, rr_nx, grant_nx, pick;
    logic [LW-1:0]   line_cnt, line_nx;
    logic            first, first_nx;
    logic            found, xfer, done_nx, err_nx;
    logic [NUM_INPUTS-1:0] req, drain;

    assign busy  = (state == STREAM);
    assign req   = s_axis_tvalid & s_axis_tuser;
    assign drain = (state == IDLE && resetn) ?
                   (s_axis_tvalid & ~s_axis_tuser) : '0;

    // first requester at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_INPUTS;
            if (!found && req[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = '0;
        m00_axis_tlast  = 1'b0;
        m00_axis_tuser  = 1'b0;
        s_axis_tready   = drain;
        if (busy) begin
            m00_axis_tvalid = s_axis_tvalid[grant_id];
            m00_axis_tdata  = s_axis_tdata[int'(grant_id)*W +: W];
            m00_axis_tlast  = s_axis_tlast[grant_id];
            m00_axis_tuser  = s_axis_tuser[grant_id];
            s_axis_tready[grant_id] = m00_axis_tready;
        end
    end

    assign xfer = m00_axis_tvalid & m00_axis_tready;

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        grant_nx = grant_id;
        line_nx  = line_cnt;
        first_nx = first;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                err_nx = |drain;
                if (enable && found) begin
                    state_nx = STREAM;
                    grant_nx = pick;
                    line_nx  = '0;
                    first_nx = 1'b1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    first_nx = 1'b0;
                    // stray SOF restarts the frame under the same grant
                    if (m00_axis_tuser && !first) begin
                        err_nx  = 1'b1;
                        line_nx = m00_axis_tlast ? LW'(1) : '0;
                    end else if (m00_axis_tlast) begin
                        if (line_cnt == LAST_LINE) begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                            line_nx  = '0;
                            rr_nx    = (grant_id == LAST_IN) ?
                                       '0 : grant_id + 1'b1;
                        end else begin
                            line_nx = line_cnt + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            line_cnt   <= '0;
            first      <= 1'b0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= rr_nx;
            grant_id   <= grant_nx;
            line_cnt   <= line_nx;
            first      <= first_nx;
            frame_done <= done_nx;
            sync_error <= err_nx;
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: source models, beat log,
// and hand-built expected frame sequences.
module tb_axis_frame_arbiter;

    localparam int W    = 24;
    localparam int N    = 4;
    localparam int H    = 10;
    localparam int LINE = 10;
    localparam int FB   = H * LINE;

    logic           clk, resetn, enable;
    logic [N-1:0]   s_axis_tvalid, s_axis_tready;
    logic [N-1:0]   s_axis_tlast, s_axis_tuser;
    logic [N*W-1:0] s_axis_tdata;
    logic           m00_axis_tvalid, m00_axis_tready;
    logic           m00_axis_tlast, m00_axis_tuser;
    logic [W-1:0]   m00_axis_tdata;
    logic [1:0]     grant_id;
    logic           busy, frame_done, sync_error;

    axis_frame_arbiter #(
        .C_AXIS_TDATA_WIDTH(W),
        .NUM_INPUTS(N),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tready(m00_axis_tready),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tuser(m00_axis_tuser),
        .grant_id(grant_id),
        .busy(busy),
        .frame_done(frame_done),
        .sync_error(sync_error)
    );

    int checks = 0;
    int failures = 0;

    int frm_left[N];
    int beat[N];
    int fno[N];
    int junk[N];
    int abort_after[N];
    bit rdy_rand;
    logic [N-1:0] hs;
    int cyc = 0;
    int bp_viol = 0;

    logic [W-1:0] lg_data[$];
    logic [W-1:0] exp_q[$];
    int lg_gid[$];
    int lg_cyc[$];
    int lg_user[$];
    int fd_cyc[$];
    int se_cyc[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i] = (junk[i] > 0) || (frm_left[i] > 0);
            s_axis_tuser[i]  = (junk[i] == 0) && (frm_left[i] > 0) &&
                               (beat[i] == 0);
            s_axis_tlast[i]  = (junk[i] == 0) && (frm_left[i] > 0) &&
                               (beat[i] % LINE == LINE - 1);
            s_axis_tdata[i*W +: W] = (junk[i] > 0) ?
                W'(24'hBAD000 + i) : {4'(i), 12'(fno[i]), 8'(beat[i])};
        end
    endtask

    // source models advance on the handshake seen at the previous negedge
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (junk[i] > 0) begin
                    junk[i]--;
                end else if (beat[i] == abort_after[i]) begin
                    beat[i] = 0;
                    abort_after[i] = -1;
                end else if (beat[i] == FB - 1) begin
                    beat[i] = 0;
                    frm_left[i]--;
                    fno[i]++;
                end else begin
                    beat[i]++;
                end
            end
        end
        m00_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
    end

    initial forever begin
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        if (m00_axis_tvalid && m00_axis_tready) begin
            lg_data.push_back(m00_axis_tdata);
            lg_gid.push_back(int'(grant_id));
            lg_cyc.push_back(cyc);
            lg_user.push_back(int'(m00_axis_tuser));
        end
        if (frame_done) fd_cyc.push_back(cyc);
        if (sync_error) se_cyc.push_back(cyc);
        if (busy) begin
            for (int i = 0; i < N; i++)
                if (i != int'(grant_id) && s_axis_tready[i]) bp_viol++;
        end else if ((s_axis_tready & s_axis_tuser) != '0) begin
            bp_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        lg_data.delete();
        lg_gid.delete();
        lg_cyc.delete();
        lg_user.delete();
        fd_cyc.delete();
        se_cyc.delete();
        exp_q.delete();
        bp_viol = 0;
    endtask

    task automatic exp_frame(input int i, input int f, input int b0,
                             input int b1);
        for (int b = b0; b <= b1; b++)
            exp_q.push_back({4'(i), 12'(f), 8'(b)});
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && fd_cyc.size() < n; k++) tick(1);
        chk(tag, fd_cyc.size(), n);
    endtask

    task automatic wait_log(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && lg_data.size() < n; k++) tick(1);
        chk(tag, lg_data.size() >= n, 1);
    endtask

    task automatic cmp_log(input string tag);
        int errs = 0;
        chk({tag, "_beats"}, lg_data.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < lg_data.size(); k++)
            if (lg_data[k] !== exp_q[k]) errs++;
        chk({tag, "_data"}, errs, 0);
    endtask

    task automatic gid_chk(input string tag, input int nfr, input int g0,
                           input int g1, input int g2);
        int errs = 0;
        int g;
        for (int k = 0; k < nfr * FB && k < lg_gid.size(); k++) begin
            g = (k / FB == 0) ? g0 : (k / FB == 1) ? g1 : g2;
            if (lg_gid[k] != g) errs++;
        end
        chk(tag, errs, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    initial begin
        int f;
        resetn = 1'b0;
        enable = 1'b1;
        m00_axis_tready = 1'b1;
        rdy_rand = 1'b0;
        hs = '0;
        for (int i = 0; i < N; i++) begin
            frm_left[i] = 0;
            beat[i] = 0;
            fno[i] = 0;
            junk[i] = 0;
            abort_after[i] = -1;
        end
        drive();
        tick(3);
        chk("rst_m00_valid", m00_axis_tvalid, 0);
        chk("rst_s_ready", s_axis_tready, 0);
        chk("rst_status", {busy, frame_done, sync_error, grant_id}, 0);
        resetn = 1'b1;
        tick(2);

        // single source
        clear_log();
        exp_frame(0, fno[0], 0, FB - 1);
        frm_left[0] = 1;
        drive();
        wait_fd("t1_fd", 1, 300);
        tick(1);
        cmp_log("t1");
        gid_chk("t1_gid", 1, 0, 0, 0);
        chk("t1_sof", lg_user[0], 1);
        chk("t1_fd_cyc", fd_cyc[0], lg_cyc[FB-1] + 1);
        chk("t1_busy_after", busy, 0);

        // contention after reset
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) begin
            exp_frame(i, fno[i], 0, FB - 1);
            frm_left[i] = 1;
        end
        drive();
        wait_fd("t2_fd", 3, 700);
        cmp_log("t2");
        gid_chk("t2_gid", 3, 0, 1, 2);
        chk("t2_contig", lg_cyc[FB-1] - lg_cyc[0], FB - 1);
        chk("t2_gap01", lg_cyc[FB] - lg_cyc[FB-1], 2);
        chk("t2_gap12", lg_cyc[2*FB] - lg_cyc[2*FB-1], 2);

        // fairness
        clear_log();
        f = fno[3];
        exp_frame(3, f, 0, FB - 1);
        exp_frame(1, fno[1], 0, FB - 1);
        exp_frame(3, f + 1, 0, FB - 1);
        frm_left[3] = 2;
        drive();
        wait_log("t3_start", 10, 100);
        frm_left[1] = 1;
        drive();
        wait_fd("t3_fd", 3, 800);
        cmp_log("t3");
        gid_chk("t3_gid", 3, 3, 1, 3);

        // backpressure
        clear_log();
        rdy_rand = 1'b1;
        exp_frame(0, fno[0], 0, FB - 1);
        exp_frame(2, fno[2], 0, FB - 1);
        frm_left[0] = 1;
        frm_left[2] = 1;
        drive();
        wait_fd("t4_fd", 2, 2000);
        rdy_rand = 1'b0;
        cmp_log("t4");
        gid_chk("t4_gid", 2, 0, 2, 0);
        chk("t4_ready_leak", bp_viol, 0);

        // drain of non-SOF beats
        clear_log();
        junk[2] = 3;
        frm_left[2] = 1;
        exp_frame(2, fno[2], 0, FB - 1);
        drive();
        wait_fd("t5_fd", 1, 400);
        chk("t5_sync_err", se_cyc.size(), 3);
        chk("t5_err_first", se_cyc[2] < lg_cyc[0], 1);
        cmp_log("t5");
        gid_chk("t5_gid", 1, 2, 2, 2);

        // mid-frame SOF on beat 25
        clear_log();
        f = fno[0];
        abort_after[0] = 23;
        frm_left[0] = 1;
        exp_frame(0, f, 0, 23);
        exp_frame(0, f, 0, FB - 1);
        drive();
        wait_fd("t6_fd", 1, 400);
        cmp_log("t6");
        chk("t6_sync_err", se_cyc.size(), 1);
        chk("t6_err_cyc", se_cyc[0], lg_cyc[24] + 1);
        chk("t6_fd_cyc", fd_cyc[0], lg_cyc[FB+23] + 1);

        // enable gating
        clear_log();
        enable = 1'b0;
        frm_left[0] = 1;
        exp_frame(0, fno[0], 0, FB - 1);
        drive();
        tick(20);
        chk("t7_no_grant", busy, 0);
        chk("t7_no_beats", lg_data.size(), 0);
        chk("t7_sof_held", s_axis_tready[0], 0);
        enable = 1'b1;
        wait_log("t7_start", 50, 200);
        enable = 1'b0;
        wait_fd("t7_fd", 1, 400);
        cmp_log("t7");
        enable = 1'b1;

        // reset mid-frame
        clear_log();
        frm_left[1] = 1;
        drive();
        wait_log("t8_start", 40, 200);
        resetn = 1'b0;
        #1;
        chk("t8_m00_valid", m00_axis_tvalid, 0);
        chk("t8_s_ready", s_axis_tready, 0);
        chk("t8_status", {busy, grant_id}, 0);
        frm_left[1] = 0;
        beat[1] = 0;
        drive();
        tick(2);
        clear_log();
        frm_left[0] = 1;
        frm_left[1] = 1;
        exp_frame(0, fno[0], 0, FB - 1);
        exp_frame(1, fno[1], 0, FB - 1);
        drive();
        tick(1);
        resetn = 1'b1;
        wait_fd("t8_fd", 2, 600);
        cmp_log("t8");
        gid_chk("t8_gid", 2, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
